// File: rtl/v_upd_ingress.sv
// Ingress FIFO and issue stage for the v block's list-update port.
// Holds commands while v is busy (BRAM init) and issues at most one per cycle.
package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [2:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [11:0] size_t;
endpackage

module v_upd_ingress #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     i_in_vld,
  input  v_pkg::id_t               i_in_prod_id,
  input  v_pkg::cmd_t              i_in_cmd,
  input  v_pkg::key_t              i_in_key,
  input  v_pkg::size_t             i_in_size,
  output logic                     o_in_rdy,
  input  logic                     i_busy,
  output logic                     o_upd_vld_r,
  output v_pkg::id_t               o_upd_prod_id_r,
  output v_pkg::cmd_t              o_upd_cmd_r,
  output v_pkg::key_t              o_upd_key_r,
  output v_pkg::size_t             o_upd_size_r,
  output logic [$clog2(DEPTH):0]   o_occ_r,
  output logic [$clog2(DEPTH):0]   o_hwm_r,
  output logic [1:0]               o_state_r
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned BW = $clog2(BOOT_CYCLES) + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef struct packed {
    v_pkg::id_t   prod_id;
    v_pkg::cmd_t  cmd;
    v_pkg::key_t  key;
    v_pkg::size_t size;
  } entry_t;

  state_t          state_r, state_nxt;
  logic [BW-1:0]   boot_cnt_r;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  entry_t          fifo_mem [DEPTH];
  entry_t          entry_in;
  logic            push, pop;
  logic [OW-1:0]   occ_nxt, hwm_nxt;

  assign entry_in = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};

  // Ready depends only on registered occupancy, so no input-to-output path.
  assign o_in_rdy  = (o_occ_r != OW'(DEPTH));
  assign push      = i_in_vld && o_in_rdy;
  assign pop       = (state_r == RUN) && !i_busy && (o_occ_r != '0);
  assign occ_nxt   = o_occ_r + OW'(push) - OW'(pop);
  assign hwm_nxt   = (occ_nxt > o_hwm_r) ? occ_nxt : o_hwm_r;
  assign o_state_r = state_r;

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      BOOT: begin
        if (i_busy)
          state_nxt = INIT;
        else if (boot_cnt_r == BW'(BOOT_CYCLES - 1))
          state_nxt = RUN;
      end
      INIT:    if (!i_busy) state_nxt = RUN;
      RUN:     if (i_busy)  state_nxt = INIT;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_r] <= entry_in;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r         <= BOOT;
      boot_cnt_r      <= '0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      o_occ_r         <= '0;
      o_hwm_r         <= '0;
      o_upd_vld_r     <= 1'b0;
      o_upd_prod_id_r <= '0;
      o_upd_cmd_r     <= '0;
      o_upd_key_r     <= '0;
      o_upd_size_r    <= '0;
    end else begin
      state_r <= state_nxt;
      if (state_r == BOOT)
        boot_cnt_r <= boot_cnt_r + BW'(1);
      if (push)
        wr_ptr_r <= wr_ptr_r + AW'(1);
      // Head is read only when occupancy was nonzero last edge, so a fresh write is never bypassed.
      if (pop) begin
        rd_ptr_r        <= rd_ptr_r + AW'(1);
        o_upd_prod_id_r <= fifo_mem[rd_ptr_r].prod_id;
        o_upd_cmd_r     <= fifo_mem[rd_ptr_r].cmd;
        o_upd_key_r     <= fifo_mem[rd_ptr_r].key;
        o_upd_size_r    <= fifo_mem[rd_ptr_r].size;
      end
      o_upd_vld_r <= pop;
      o_occ_r     <= occ_nxt;
      o_hwm_r     <= hwm_nxt;
    end
  end

endmodule

// File: tb/tb_v_upd_ingress.sv
// Scoreboard bench for v_upd_ingress: a queue-level reference model predicts
// occupancy, state and issue timing; accepted commands are checked in order.
module tb_v_upd_ingress;
  import v_pkg::*;

  localparam int DEPTH       = 8;
  localparam int BOOT_CYCLES = 4;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } cmd_s;

  logic        clk, arst_n, i_in_vld, o_in_rdy, i_busy, o_upd_vld_r;
  id_t         i_in_prod_id, o_upd_prod_id_r;
  cmd_t        i_in_cmd, o_upd_cmd_r;
  key_t        i_in_key, o_upd_key_r;
  size_t       i_in_size, o_upd_size_r;
  logic [3:0]  o_occ_r, o_hwm_r;
  logic [1:0]  o_state_r;

  v_upd_ingress #(.DEPTH(DEPTH), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_in_vld(i_in_vld), .i_in_prod_id(i_in_prod_id), .i_in_cmd(i_in_cmd),
    .i_in_key(i_in_key), .i_in_size(i_in_size), .o_in_rdy(o_in_rdy),
    .i_busy(i_busy), .o_upd_vld_r(o_upd_vld_r),
    .o_upd_prod_id_r(o_upd_prod_id_r), .o_upd_cmd_r(o_upd_cmd_r),
    .o_upd_key_r(o_upd_key_r), .o_upd_size_r(o_upd_size_r),
    .o_occ_r(o_occ_r), .o_hwm_r(o_hwm_r), .o_state_r(o_state_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   mocc = 0, mhwm = 0, mstate = 0, mage = 0;
  bit   mvld = 0, acc = 0;
  int   issued = 0;
  int   max_occ = 0;
  cmd_s sbq[$];
  cmd_s pend[$];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_s mk(input id_t p, input key_t k);
    cmd_s c;
    c.prod_id = p;
    c.cmd     = cmd_t'($urandom);
    c.key     = k;
    c.size    = size_t'($urandom);
    return c;
  endfunction

  // Reference model: queue-count view of the buffer and the boot/init/run rules.
  always @(posedge clk) begin
    if (!arst_n) begin
      mocc = 0; mhwm = 0; mstate = 0; mage = 0; mvld = 0; acc = 0;
      sbq.delete();
    end else begin
      bit pop_m;
      pop_m = (mstate == 2) && !i_busy && (mocc > 0);
      acc   = i_in_vld && (mocc < DEPTH);
      if (acc) sbq.push_back({i_in_prod_id, i_in_cmd, i_in_key, i_in_size});
      mvld = pop_m;
      mocc = mocc + int'(acc) - int'(pop_m);
      if (mocc > mhwm) mhwm = mocc;
      case (mstate)
        0: begin
          mage++;
          if (i_busy) mstate = 1;
          else if (mage >= BOOT_CYCLES) mstate = 2;
        end
        1: if (!i_busy) mstate = 2;
        default: if (i_busy) mstate = 1;
      endcase
    end
  end

  // Upstream driver: presents the head of pend and holds it until accepted.
  always @(negedge clk) begin
    if (acc) begin
      pend.delete(0);
      acc = 0;
    end
    if (pend.size() > 0) begin
      i_in_vld = 1'b1;
      {i_in_prod_id, i_in_cmd, i_in_key, i_in_size} = pend[0];
    end else begin
      i_in_vld = 1'b0;
    end
  end

  // Monitor: compares against model each cycle and pops the scoreboard on issue.
  always @(negedge clk) begin
    if (arst_n) begin
      chk("occ", o_occ_r, mocc);
      chk("hwm", o_hwm_r, mhwm);
      chk("state", o_state_r, mstate);
      chk("in_rdy", o_in_rdy, (mocc != DEPTH));
      chk("upd_vld", o_upd_vld_r, mvld);
      if (int'(o_occ_r) > max_occ) max_occ = int'(o_occ_r);
      if (o_upd_vld_r) begin
        issued++;
        if (sbq.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          cmd_s e;
          e = sbq.pop_front();
          chk("prod_id", o_upd_prod_id_r, e.prod_id);
          chk("cmd", o_upd_cmd_r, e.cmd);
          chk("key", o_upd_key_r, e.key);
          chk("size", o_upd_size_r, e.size);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    chk("rst_occ", o_occ_r, 0);
    chk("rst_hwm", o_hwm_r, 0);
    chk("rst_vld", o_upd_vld_r, 0);
    chk("rst_fields", {o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}, 0);
    chk("rst_state", o_state_r, 0);
    chk("rst_rdy", o_in_rdy, 1);
    @(posedge clk);
    #3 arst_n = 1'b1;
  endtask

  task automatic wait_issued(input int target, input int budget);
    int n = 0;
    while (issued < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_issue", issued, target);
  endtask

  initial begin
    int base;
    arst_n = 1'b0; i_busy = 1'b0; i_in_vld = 1'b0;
    i_in_prod_id = '0; i_in_cmd = '0; i_in_key = '0; i_in_size = '0;

    // BOOT timeout with i_busy tied low and one push right after release
    pend.push_back(mk(8'd9, 16'h1234));
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("boot_still", o_state_r, 0);
    @(posedge clk);
    #1 chk("boot_to_run", o_state_r, 2);
    wait_issued(1, 20);

    // Boot hold: busy during BRAM init, three queued commands
    base = issued;
    do_reset();
    @(negedge clk) i_busy = 1'b1;
    for (int i = 1; i <= 3; i++) pend.push_back(mk(id_t'(i), key_t'(i * 16)));
    repeat (19) @(negedge clk);
    chk("hold_no_issue", issued, base);
    i_busy = 1'b0;
    wait_issued(base + 3, 20);
    chk("hold_hwm", o_hwm_r, 3);

    // Full stall: 10 offered with v busy, 8 accepted
    base = issued;
    @(negedge clk) i_busy = 1'b1;
    for (int i = 0; i < 10; i++) pend.push_back(mk(id_t'(20 + i), key_t'(16'h100 + i)));
    repeat (15) @(negedge clk);
    #1;
    chk("full_occ", o_occ_r, 8);
    chk("full_rdy", o_in_rdy, 0);
    chk("full_pending", pend.size(), 2);
    @(negedge clk) i_busy = 1'b0;
    wait_issued(base + 10, 40);
    chk("full_hwm", o_hwm_r, 8);

    // Streaming: back-to-back pushes and pops
    base = issued;
    @(negedge clk) max_occ = 0;
    for (int i = 0; i < 100; i++) pend.push_back(mk(id_t'(i), key_t'(16'h2000 + i)));
    wait_issued(base + 100, 200);
    chk("stream_max_occ", max_occ, 1);

    // Busy pulse after the second issue
    base = issued;
    for (int i = 0; i < 6; i++) pend.push_back(mk(id_t'(40 + i), key_t'(16'h3000 + i)));
    wait_issued(base + 2, 20);
    @(negedge clk) i_busy = 1'b1;
    repeat (3) @(negedge clk);
    i_busy = 1'b0;
    wait_issued(base + 6, 40);

    // Reset mid-operation with five entries queued
    @(negedge clk) i_busy = 1'b1;
    for (int i = 0; i < 5; i++) pend.push_back(mk(id_t'(60 + i), key_t'(16'h4000 + i)));
    repeat (10) @(negedge clk);
    #1 chk("pre_rst_occ", o_occ_r, 5);
    base = issued;
    do_reset();
    @(negedge clk) i_busy = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("post_rst_issues", issued, base);
    chk("post_rst_occ", o_occ_r, 0);

    // Randomized traffic with random busy
    repeat (400) begin
      @(negedge clk);
      i_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1 && pend.size() < 4)
        pend.push_back(mk(id_t'($urandom), key_t'($urandom)));
    end
    i_busy = 1'b0;
    begin
      int n = 0;
      while ((pend.size() != 0 || mocc != 0 || sbq.size() != 0) && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    chk("drain_sbq", sbq.size(), 0);
    chk("drain_pend", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
